multi_bounded_counter: RTL and testbench

- N-channel up/down position counter: each channel holds a value inside programmable [min_bound, max_bound] limits.
- Adds over the single-channel counter:
  - channel count, step size and lower bound are all parametrised or runtime-set;
  - saturate or wrap mode;
  - a shared rate prescaler;
  - synchronous load;
  - boundary flags and a move strobe.
- Drives paddle and ball coordinates in the game datapath, one channel per axis or object.

---
 rtl/multi_bounded_counter_pkg.sv | 26 ++
 rtl/multi_bounded_counter_cell.sv | 102 ++++++++++
 rtl/multi_bounded_counter.sv | 75 +++++++
 tb/tb_multi_bounded_counter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_bounded_counter_pkg.sv
// Shared constants and helpers for the multi-channel bounded counter.
// Channel i of every flattened bus occupies bits [i*W +: W].
package multi_bounded_counter_pkg;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  typedef enum logic [1:0] {
    MV_HOLD = 2'd0,
    MV_UP   = 2'd1,
    MV_DOWN = 2'd2
  } move_e;

  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

  function automatic move_e move_dir(input logic up, input logic dn);
    move_e m;
    m = MV_HOLD;
    if (up && !dn) m = MV_UP;
    if (dn && !up) m = MV_DOWN;
    return m;
  endfunction

endpackage

// File: rtl/multi_bounded_counter_cell.sv
// One channel: count register, bounded next-value arithmetic,
// boundary flags and the registered moved strobe.
module bounded_step_cell
  import multi_bounded_counter_pkg::*;
#(
  parameter int BIT_WIDTH = 10,
  parameter int STEP_W    = 4,
  parameter logic [BIT_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_tick,
  input  logic                 i_bounds_ok,
  input  logic [BIT_WIDTH-1:0] i_min,
  input  logic [BIT_WIDTH-1:0] i_max,
  input  logic [STEP_W-1:0]    i_step,
  input  logic                 i_wrap,
  input  logic                 i_inc,
  input  logic                 i_dec,
  input  logic                 i_load,
  input  logic [BIT_WIDTH-1:0] i_load_val,
  output logic [BIT_WIDTH-1:0] o_count,
  output logic                 o_at_min,
  output logic                 o_at_max,
  output logic                 o_moved
);

  localparam int EW = BIT_WIDTH + 1;

  logic [BIT_WIDTH-1:0] r_count;
  logic                 r_moved;

  logic [EW-1:0] w_cnt_x;
  logic [EW-1:0] w_min_x;
  logic [EW-1:0] w_max_x;
  logic [EW-1:0] w_step_x;
  logic [EW-1:0] w_sum;
  logic [EW-1:0] w_floor;
  logic [BIT_WIDTH-1:0] w_load_c;
  logic [BIT_WIDTH-1:0] w_next;
  move_e w_dir;

  assign w_cnt_x  = {1'b0, r_count};
  assign w_min_x  = {1'b0, i_min};
  assign w_max_x  = {1'b0, i_max};
  assign w_step_x = EW'(i_step);
  // One extra bit keeps count+step and min+step from wrapping.
  assign w_sum    = w_cnt_x + w_step_x;
  assign w_floor  = w_min_x + w_step_x;
  assign w_dir    = move_dir(i_inc, i_dec);

  always_comb begin
    w_load_c = i_load_val;
    if (i_load_val < i_min) w_load_c = i_min;
    if (i_load_val > i_max) w_load_c = i_max;
  end

  always_comb begin
    w_next = r_count;
    if (!i_bounds_ok) begin
      w_next = r_count;
    end else if (i_load) begin
      w_next = w_load_c;
    end else if (i_tick && (i_step != '0)) begin
      case (w_dir)
        MV_UP: begin
          if (r_count < i_min)
            w_next = i_min;
          else if (w_sum <= w_max_x)
            w_next = w_sum[BIT_WIDTH-1:0];
          else
            w_next = (i_wrap == MODE_WRAP) ? i_min : i_max;
        end
        MV_DOWN: begin
          if (r_count > i_max)
            w_next = i_max;
          else if (w_cnt_x >= w_floor)
            w_next = r_count - BIT_WIDTH'(i_step);
          else
            w_next = (i_wrap == MODE_WRAP) ? i_max : i_min;
        end
        default: w_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= INIT_VAL;
      r_moved <= 1'b0;
    end else begin
      r_count <= w_next;
      r_moved <= (w_next != r_count);
    end
  end

  assign o_count  = r_count;
  assign o_moved  = r_moved;
  assign o_at_min = i_bounds_ok && (r_count == i_min);
  assign o_at_max = i_bounds_ok && (r_count == i_max);

endmodule

// File: rtl/multi_bounded_counter.sv
// N-channel bounded up/down position counter with a shared
// rate prescaler, saturate/wrap modes and synchronous load.
module multi_bounded_counter
  import multi_bounded_counter_pkg::*;
#(
  parameter int BIT_WIDTH = 10,
  parameter int N_CH      = 2,
  parameter int STEP_W    = 4,
  parameter int DIV_W     = 16,
  parameter int INIT_VAL  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIV_W-1:0]          rate_div,
  input  logic [BIT_WIDTH-1:0]      min_bound,
  input  logic [BIT_WIDTH-1:0]      max_bound,
  input  logic [STEP_W-1:0]         step,
  input  logic                      wrap_mode,
  input  logic [N_CH-1:0]           inc,
  input  logic [N_CH-1:0]           dec,
  input  logic [N_CH-1:0]           load,
  input  logic [N_CH*BIT_WIDTH-1:0] load_val,
  output logic [N_CH*BIT_WIDTH-1:0] count,
  output logic [N_CH-1:0]           at_min,
  output logic [N_CH-1:0]           at_max,
  output logic [N_CH-1:0]           moved
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_tick;
  logic             w_bounds_ok;

  assign w_div_eff   = (rate_div == '0) ? DIV_W'(1) : rate_div;
  // >= lets a shrunken divisor tick right away instead of overrunning.
  assign w_tick      = (r_div >= (w_div_eff - DIV_W'(1)));
  assign w_bounds_ok = (min_bound <= max_bound);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_div <= '0;
    else if (w_tick)
      r_div <= '0;
    else
      r_div <= r_div + DIV_W'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam int LSB = ch_lsb(i, BIT_WIDTH);

    bounded_step_cell #(
      .BIT_WIDTH (BIT_WIDTH),
      .STEP_W    (STEP_W),
      .INIT_VAL  (BIT_WIDTH'(INIT_VAL))
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .i_tick     (w_tick),
      .i_bounds_ok(w_bounds_ok),
      .i_min      (min_bound),
      .i_max      (max_bound),
      .i_step     (step),
      .i_wrap     (wrap_mode),
      .i_inc      (inc[i]),
      .i_dec      (dec[i]),
      .i_load     (load[i]),
      .i_load_val (load_val[LSB +: BIT_WIDTH]),
      .o_count    (count[LSB +: BIT_WIDTH]),
      .o_at_min   (at_min[i]),
      .o_at_max   (at_max[i]),
      .o_moved    (moved[i])
    );
  end

endmodule

// File: tb/tb_multi_bounded_counter.sv
// Directed bench for multi_bounded_counter with hand-computed
// expectations, default parameters (10-bit, 2 channels).
module tb_multi_bounded_counter;

  localparam int BW = 10;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   rate_div;
  logic [BW-1:0] min_bound;
  logic [BW-1:0] max_bound;
  logic [3:0]    step;
  logic          wrap_mode;
  logic [NC-1:0] inc;
  logic [NC-1:0] dec;
  logic [NC-1:0] load;
  logic [NC*BW-1:0] load_val;
  logic [NC*BW-1:0] count;
  logic [NC-1:0] at_min;
  logic [NC-1:0] at_max;
  logic [NC-1:0] moved;

  int errs = 0;
  int checks = 0;

  multi_bounded_counter dut (
    .clk       (clk),
    .reset     (reset),
    .rate_div  (rate_div),
    .min_bound (min_bound),
    .max_bound (max_bound),
    .step      (step),
    .wrap_mode (wrap_mode),
    .inc       (inc),
    .dec       (dec),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .at_min    (at_min),
    .at_max    (at_max),
    .moved     (moved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int c0();
    return int'(count[BW-1:0]);
  endfunction

  function automatic int c1();
    return int'(count[2*BW-1:BW]);
  endfunction

  task automatic load0(input int v);
    load = 2'b01;
    load_val[BW-1:0] = BW'(v);
    tick_n(1);
    load = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    rate_div = 16'd1;
    min_bound = 10'd0;
    max_bound = 10'd479;
    step = 4'd4;
    wrap_mode = 1'b0;
    inc = '0;
    dec = '0;
    load = '0;
    load_val = '0;
    tick_n(2);
    chk("rst_c0", c0(), 0);
    chk("rst_c1", c1(), 0);
    chk("rst_moved", int'(moved), 0);
    chk("rst_at_min", int'(at_min), 3);

    reset = 1'b0;
    inc = 2'b01;
    tick_n(1);
    chk("ramp_c0_4", c0(), 4);
    chk("ramp_mv0", int'(moved), 1);
    tick_n(1);
    chk("ramp_c0_8", c0(), 8);
    tick_n(1);
    chk("ramp_c0_12", c0(), 12);
    chk("ramp_mv_12", int'(moved), 1);
    chk("ramp_c1", c1(), 0);

    inc = 2'b00;
    load0(476);
    chk("ld_476", c0(), 476);
    chk("ld_mv", int'(moved), 1);
    inc = 2'b01;
    tick_n(1);
    chk("sat_479", c0(), 479);
    chk("sat_atmax", int'(at_max), 1);
    chk("sat_mv", int'(moved), 1);
    tick_n(1);
    chk("sat_hold", c0(), 479);
    chk("sat_nomv", int'(moved), 0);

    wrap_mode = 1'b1;
    tick_n(1);
    chk("wrap_up", c0(), 0);
    chk("wrap_atmin", int'(at_min), 3);
    inc = 2'b00;
    load0(2);
    dec = 2'b01;
    tick_n(1);
    chk("wrap_dn", c0(), 479);
    dec = 2'b00;

    load0(100);
    rate_div = 16'd3;
    inc = 2'b01;
    tick_n(1);
    chk("div_e1", c0(), 100);
    tick_n(1);
    chk("div_e2", c0(), 100);
    tick_n(1);
    chk("div_e3", c0(), 104);
    tick_n(2);
    chk("div_e5", c0(), 104);
    chk("div_e5_mv", int'(moved), 0);
    tick_n(1);
    chk("div_e6", c0(), 108);
    rate_div = 16'd0;
    tick_n(1);
    chk("div0_e1", c0(), 112);
    tick_n(1);
    chk("div0_e2", c0(), 116);

    load = 2'b01;
    load_val[BW-1:0] = 10'd900;
    tick_n(1);
    chk("ld_clamp", c0(), 479);
    chk("ld_clamp_mv", int'(moved), 1);
    tick_n(1);
    chk("ld_same_mv", int'(moved), 0);
    load = 2'b00;
    inc = 2'b01;
    dec = 2'b01;
    wrap_mode = 1'b0;
    tick_n(1);
    chk("both_hold", c0(), 479);
    chk("both_mv", int'(moved), 0);
    inc = 2'b10;
    dec = 2'b00;
    tick_n(1);
    chk("ch1_inc", c1(), 4);
    chk("ch1_ch0_hold", c0(), 479);

    inc = 2'b00;
    load0(200);
    inc = 2'b01;
    tick_n(1);
    chk("ramp2", c0(), 204);
    #3;
    reset = 1'b1;
    #1;
    chk("async_c0", c0(), 0);
    chk("async_c1", c1(), 0);
    chk("async_mv", int'(moved), 0);
    tick_n(1);
    reset = 1'b0;

    min_bound = 10'd300;
    max_bound = 10'd100;
    tick_n(2);
    chk("inv_hold", c0(), 0);
    chk("inv_flags", int'({at_min, at_max}), 0);
    load0(200);
    chk("inv_noload", c0(), 0);

    min_bound = 10'd0;
    max_bound = 10'd0;
    #1;
    chk("eq_atmin", int'(at_min), 3);
    chk("eq_atmax", int'(at_max), 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
